// File: rtl/h14tx_pkt_scheduler.sv
// Data-island packet scheduler: arbitrates NumSrc packet producers into one
// packet per 32-cycle slot. It inserts null packets when no source is eligible.
module h14tx_pkt_scheduler #(
    parameter int       NumSrc       = 4,
    parameter int       MaxSlots     = 18,
    parameter bit       Src0Priority = 1'b1,
    parameter int       PktW         = 248,
    // Period encoding shared with h14tx_timings_top
    parameter int       PerW         = 3,
    parameter logic [2:0] PerCtrl    = 3'd0,
    parameter logic [2:0] PerDiPre   = 3'd4,
    parameter logic [2:0] PerDiGuard = 3'd5,
    parameter logic [2:0] PerDiAct   = 3'd6
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [PerW-1:0]              period,
    input  logic [NumSrc-1:0]            src_req,
    input  logic [NumSrc-1:0][PktW-1:0]  src_pkt,
    output logic [NumSrc-1:0]            src_ack,
    output logic [PktW-1:0]              pkt,
    output logic                         pkt_null,
    output logic [4:0]                   slot,
    output logic                         err_trunc
);

    localparam int PtrW = (NumSrc > 1) ? $clog2(NumSrc) : 1;

    logic [PerW-1:0] r_prev_period;
    logic [4:0]      r_cnt;
    logic [4:0]      r_slot;
    logic [PktW-1:0] r_pkt;
    logic            r_null;
    logic            r_trunc;
    logic [PtrW-1:0] r_ptr;

    logic            w_load0;
    logic            w_loadn;
    logic            w_load;
    logic [4:0]      w_fill_slot;
    logic            w_elig;
    logic            w_prio;
    logic [PtrW-1:0] w_gidx;
    logic            w_trunc;

    assign w_load0     = (period == PerW'(PerDiGuard)) && (r_prev_period == PerW'(PerDiPre));
    assign w_loadn     = (period == PerW'(PerDiAct)) && (r_cnt == 5'd31);
    assign w_load      = w_load0 || w_loadn;
    assign w_fill_slot = w_load0 ? 5'd0 : ((r_slot == 5'd31) ? 5'd31 : r_slot + 5'd1);
    assign w_elig      = w_load && (int'(w_fill_slot) < MaxSlots) && (|src_req);
    assign w_prio      = Src0Priority && src_req[0];

    // A clean island ends right after cnt wrapped 31 -> 0, so any other
    // count on the first non-active cycle means the island was cut short.
    assign w_trunc = (r_prev_period == PerW'(PerDiAct)) && (period != PerW'(PerDiAct)) &&
                     (r_cnt != 5'd0);

    always_comb begin
        logic found;
        int   j;
        w_gidx = '0;
        found  = 1'b0;
        j      = 0;
        if (w_prio) begin
            found = 1'b1;
        end else begin
            for (int k = 0; k < NumSrc; k++) begin
                j = int'(r_ptr) + k;
                if (j >= NumSrc) j = j - NumSrc;
                if (!found && src_req[j]) begin
                    found  = 1'b1;
                    w_gidx = PtrW'(j);
                end
            end
        end
    end

    always_comb begin
        src_ack = '0;
        if (w_elig) src_ack[w_gidx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_period <= PerW'(PerCtrl);
            r_cnt         <= '0;
            r_slot        <= '0;
            r_pkt         <= '0;
            r_null        <= 1'b1;
            r_trunc       <= 1'b0;
            r_ptr         <= '0;
        end else begin
            r_prev_period <= period;
            r_cnt         <= (period == PerW'(PerDiAct)) ? r_cnt + 5'd1 : 5'd0;
            if (w_trunc) r_trunc <= 1'b1;
            if (w_load) begin
                r_slot <= w_fill_slot;
                r_pkt  <= w_elig ? src_pkt[w_gidx] : '0;
                r_null <= !w_elig;
                if (w_elig && !w_prio)
                    r_ptr <= (w_gidx == PtrW'(NumSrc - 1)) ? '0 : w_gidx + PtrW'(1);
            end
        end
    end

    assign pkt       = r_pkt;
    assign pkt_null  = r_null;
    assign slot      = r_slot;
    assign err_trunc = r_trunc;

endmodule
